// File: rtl/ftrans_rot.sv
// ftrans_rot: -j / +j trivial-twiddle rotator with elastic 2-stage pipeline.
// Define FTRANS_SAT_EN to saturate negation of the most-negative value.
module ftrans_rot #(
  parameter int DATA_W      = 16,
  parameter int TOTAL_STAGE = 10,
  parameter int STG_W       = 4
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   ien,
  output logic                   irdy,
  input  logic [2*DATA_W-1:0]    idata,
  input  logic [TOTAL_STAGE-1:0] iaddr,
  input  logic [STG_W-1:0]       istg,
  input  logic                   iinv,
  output logic                   oen,
  input  logic                   ordy,
  output logic [2*DATA_W-1:0]    odata,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic                   osat,
  output logic                   oerr
);

  localparam int XW = 1 << STG_W;

  localparam logic [STG_W-1:0] STG_RST =
    STG_W'(TOTAL_STAGE);

  localparam logic [DATA_W-1:0] MIN_V =
    {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [DATA_W-1:0] MAX_V =
    {1'b0, {(DATA_W-1){1'b1}}};

  typedef struct packed {
    logic                   v;
    logic                   rot;
    logic                   inv;
    logic [DATA_W-1:0]      re;
    logic [DATA_W-1:0]      im;
    logic [TOTAL_STAGE-1:0] addr;
  } s1_t;

  typedef struct packed {
    logic                   v;
    logic                   sat;
    logic [2*DATA_W-1:0]    data;
    logic [TOTAL_STAGE-1:0] addr;
  } s2_t;

  // Returns {saturated, -x} in DATA_W bits.
  function automatic logic [DATA_W:0] neg_f(
    input logic [DATA_W-1:0] x
  );
`ifdef FTRANS_SAT_EN
    if (x == MIN_V) begin
      return {1'b1, MAX_V};
    end
`endif
    return {1'b0, (~x) + DATA_W'(1)};
  endfunction

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [STG_W-1:0]       stg_q, stg_d;
  logic                   inv_q, inv_d;
  logic [TOTAL_STAGE-1:0] exp_q, exp_d;
  logic                   err_q, err_d;

  logic                   s2_load;
  logic                   acc;
  logic                   frame0;
  logic [STG_W-1:0]       stg_eff;
  logic                   inv_eff;
  logic [STG_W-1:0]       stg_m1;
  logic [STG_W-1:0]       stg_m2;
  logic [XW-1:0]          addr_x;
  logic                   rot_dec;
  logic [TOTAL_STAGE-1:0] mask;

  logic [DATA_W:0]        neg_re;
  logic [DATA_W:0]        neg_im;
  logic [DATA_W-1:0]      r_re;
  logic [DATA_W-1:0]      r_im;
  logic                   r_sat;

  // Handshake and frame-start config selection
  always_comb begin
    s2_load = !s2_q.v | ordy;
    irdy    = !irst & (!s1_q.v | s2_load);
    acc     = ien & irdy;
    frame0  = (iaddr == '0);
    stg_eff = frame0 ? istg : stg_q;
    inv_eff = frame0 ? iinv : inv_q;
  end

  // Rotate bits beyond the address width read as zero
  always_comb begin
    addr_x = '0;
    addr_x[TOTAL_STAGE-1:0] = iaddr;
    stg_m1  = stg_eff - STG_W'(1);
    stg_m2  = stg_eff - STG_W'(2);
    rot_dec = (stg_eff >= STG_W'(2))
            & addr_x[stg_m1]
            & addr_x[stg_m2];
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < TOTAL_STAGE; i++) begin
      mask[i] = (i < int'(stg_eff));
    end
  end

  always_comb begin
    stg_d = stg_q;
    inv_d = inv_q;
    exp_d = exp_q;
    err_d = err_q;
    if (acc) begin
      if (frame0) begin
        stg_d = istg;
        inv_d = iinv;
        exp_d = TOTAL_STAGE'(1) & mask;
      end else begin
        if (iaddr != exp_q) begin
          err_d = 1'b1;
        end
        exp_d = (iaddr + TOTAL_STAGE'(1)) & mask;
      end
    end
  end

  always_comb begin
    s1_d = s1_q;
    if (acc) begin
      s1_d.v    = 1'b1;
      s1_d.rot  = rot_dec;
      s1_d.inv  = inv_eff;
      s1_d.re   = idata[2*DATA_W-1:DATA_W];
      s1_d.im   = idata[DATA_W-1:0];
      s1_d.addr = iaddr;
    end else if (s2_load) begin
      s1_d.v = 1'b0;
    end
  end

  always_comb begin
    neg_re = neg_f(s1_q.re);
    neg_im = neg_f(s1_q.im);
    r_re   = s1_q.re;
    r_im   = s1_q.im;
    r_sat  = 1'b0;
    unique case (1'b1)
      !s1_q.rot: begin
        r_re  = s1_q.re;
        r_im  = s1_q.im;
      end
      s1_q.rot & !s1_q.inv: begin
        r_re  = s1_q.im;
        r_im  = neg_re[DATA_W-1:0];
        r_sat = neg_re[DATA_W];
      end
      s1_q.rot & s1_q.inv: begin
        r_re  = neg_im[DATA_W-1:0];
        r_im  = s1_q.re;
        r_sat = neg_im[DATA_W];
      end
    endcase
  end

  // osat is cleared on drain so it only pulses with oen
  always_comb begin
    s2_d = s2_q;
    if (s2_load) begin
      s2_d.v = s1_q.v;
      if (s1_q.v) begin
        s2_d.data = {r_re, r_im};
        s2_d.addr = s1_q.addr;
        s2_d.sat  = r_sat;
      end else begin
        s2_d.sat  = 1'b0;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      stg_q <= STG_RST;
      inv_q <= 1'b0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      stg_q <= stg_d;
      inv_q <= inv_d;
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    oen   = s2_q.v;
    odata = s2_q.data;
    oaddr = s2_q.addr;
    osat  = s2_q.sat;
    oerr  = err_q;
  end

endmodule

// File: tb/tb_ftrans_rot.sv
// tb_ftrans_rot: directed and randomized checks of ftrans_rot
// against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_ftrans_rot;

  localparam int TS = 10;

  logic        clk = 1'b0;
  logic        irst, ien, irdy, iinv;
  logic        oen, ordy, osat, oerr;
  logic [31:0] idata, odata;
  logic [9:0]  iaddr, oaddr;
  logic [3:0]  istg;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] q_data[$];
  logic [9:0]  q_addr[$];
  logic        q_sat[$];
  int          m_stg, m_inv, m_exp;
  bit          m_err;

  localparam logic [31:0] PASS_V  = {16'd100, 16'hFF38};
  localparam logic [31:0] ROT_F_V = {16'hFF38, 16'hFF9C};
  localparam logic [31:0] ROT_I_V = {16'd200, 16'd100};

  always #5 clk = ~clk;

  ftrans_rot dut (
    .iclk (clk),
    .irst (irst),
    .ien  (ien),
    .irdy (irdy),
    .idata(idata),
    .iaddr(iaddr),
    .istg (istg),
    .iinv (iinv),
    .oen  (oen),
    .ordy (ordy),
    .odata(odata),
    .oaddr(oaddr),
    .osat (osat),
    .oerr (oerr)
  );

  function automatic int mask_of(int s);
    if (s >= TS) return (1 << TS) - 1;
    return (1 << s) - 1;
  endfunction

  function automatic int neg_ref(int x, output bit sat);
    sat = 1'b0;
    if (-x <= 32767) return -x;
`ifdef FTRANS_SAT_EN
    sat = 1'b1;
    return 32767;
`else
    return -x - 65536;
`endif
  endfunction

  function automatic logic [32:0] ref_out(
    logic [31:0] d, int a, int s, int inv
  );
    int re, im, ore, oim;
    bit rot, sat;
    re  = int'($signed(d[31:16]));
    im  = int'($signed(d[15:0]));
    rot = (s >= 2) && (((a >> (s-1)) & 1) == 1)
                   && (((a >> (s-2)) & 1) == 1);
    sat = 1'b0;
    ore = re;
    oim = im;
    if (rot && inv == 0) begin
      ore = im;
      oim = neg_ref(re, sat);
    end else if (rot) begin
      ore = neg_ref(im, sat);
      oim = re;
    end
    return {sat, 16'(ore), 16'(oim)};
  endfunction

  task automatic model_accept(
    logic [31:0] d, int a, int s, int inv
  );
    logic [32:0] r;
    if (a == 0) begin
      m_stg = s;
      m_inv = inv;
    end
    r = ref_out(d, a, m_stg, m_inv);
    q_data.push_back(r[31:0]);
    q_sat.push_back(r[32]);
    q_addr.push_back(10'(a));
    if (a == 0) begin
      m_exp = 1 & mask_of(m_stg);
    end else begin
      if (a != m_exp) m_err = 1'b1;
      m_exp = (a + 1) & mask_of(m_stg);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    irst = 1'b1; ien = 1'b0; ordy = 1'b1;
    iaddr = '0; idata = '0; istg = '0; iinv = 1'b0;
    @(posedge clk); #1;
    irst = 1'b0;
    m_stg = TS; m_inv = 0; m_exp = 0; m_err = 1'b0;
    q_data.delete(); q_addr.delete(); q_sat.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++;
    if (oen !== 1'b0) begin
      n_fail++; $display("FAIL rst_oen got=%b exp=0", oen);
    end
    n_run++;
    if (odata !== 32'd0 || oaddr !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_data got=%h/%h exp=0", odata, oaddr);
    end
    n_run++;
    if (osat !== 1'b0 || oerr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got=%b%b exp=00", osat, oerr);
    end
    n_run++;
    if (irdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_irdy got=%b exp=0", irdy);
    end
  endtask

  task automatic test_forward();
    logic [31:0] e;
    do_reset();
    istg = 4'd4; iinv = 1'b0; ordy = 1'b1;
    idata = PASS_V;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ien   = (i < 16);
      iaddr = 10'(i % 16);
      @(negedge clk);
      n_run++;
      if (oen !== (i >= 2 && i < 18)) begin
        n_fail++;
        $display("FAIL fwd_lat cyc=%0d got=%b", i, oen);
      end
      if (oen === 1'b1 && i >= 2 && i < 18) begin
        e = (i - 2 >= 12) ? ROT_F_V : PASS_V;
        n_run++;
        if (odata !== e || oaddr !== 10'(i-2)) begin
          n_fail++;
          $display("FAIL fwd_data a=%0d got=%h@%0d exp=%h",
                   i-2, odata, oaddr, e);
        end
      end
    end
    ien = 1'b0;
    n_run++;
    if (oerr !== 1'b0) begin
      n_fail++; $display("FAIL fwd_err got=%b exp=0", oerr);
    end
  endtask

  task automatic test_inverse();
    logic [31:0] e;
    int j, a;
    do_reset();
    istg = 4'd4; ordy = 1'b1; idata = PASS_V;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1;
      ien   = (i < 32);
      iaddr = 10'(i % 16);
      if (i < 16) iinv = (i % 16) < 5;
      else        iinv = (i % 16) != 0;
      @(negedge clk);
      j = i - 2;
      a = j % 16;
      if (oen === 1'b1 && j >= 0) begin
        if (a < 12)      e = PASS_V;
        else if (j < 16) e = ROT_I_V;
        else             e = ROT_F_V;
        n_run++;
        if (odata !== e) begin
          n_fail++;
          $display("FAIL inv_data j=%0d got=%h exp=%h",
                   j, odata, e);
        end
      end
    end
    ien = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    logic        es;
    int          seen;
    do_reset();
    istg = 4'd4; iinv = 1'b0; ordy = 1'b1;
    seen = 0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      ien   = (i < 14);
      iaddr = 10'(i);
      if (i == 12)      idata = {16'h8000, 16'd5};
      else if (i == 13) idata = {16'd7, 16'h8000};
      else              idata = {16'd1, 16'd2};
      @(negedge clk);
      if (oen === 1'b1) begin
        seen++;
        es = 1'b0;
        if (oaddr == 10'd12) begin
`ifdef FTRANS_SAT_EN
          e = {16'd5, 16'h7FFF}; es = 1'b1;
`else
          e = {16'd5, 16'h8000};
`endif
        end else if (oaddr == 10'd13) begin
          e = {16'h8000, 16'hFFF9};
        end else begin
          e = {16'd1, 16'd2};
        end
        n_run++;
        if (odata !== e || osat !== es) begin
          n_fail++;
          $display("FAIL sat a=%0d got=%h/%b exp=%h/%b",
                   oaddr, odata, osat, e, es);
        end
      end
    end
    ien = 1'b0;
    n_run++;
    if (seen != 14) begin
      n_fail++; $display("FAIL sat_count got=%0d exp=14", seen);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cur;
    logic [43:0] held;
    bit          have, stalled;
    int          sent, got;
    do_reset();
    sent = 0; got = 0; have = 0; stalled = 0; held = '0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(posedge clk); #1;
      ordy = (c % 4 == 0) || (c % 4 == 3);
      if (!have) begin
        cur  = $urandom;
        have = 1;
      end
      ien = (sent < 16); idata = cur;
      iaddr = 10'(sent); istg = 4'd4; iinv = 1'b0;
      @(negedge clk);
      if (stalled) begin
        n_run++;
        if ({oen, odata, oaddr, osat} !== held) begin
          n_fail++;
          $display("FAIL bp_hold got=%h exp=%h",
                   {oen, odata, oaddr, osat}, held);
        end
      end
      n_run++;
      if (irdy !== !(q_data.size() == 2 && !ordy)) begin
        n_fail++;
        $display("FAIL bp_irdy got=%b occ=%0d ordy=%b",
                 irdy, q_data.size(), ordy);
      end
      if (oen === 1'b1 && ordy) begin
        n_run++;
        if (q_data.size() == 0) begin
          n_fail++; $display("FAIL bp_extra got=%h exp=none", odata);
        end else begin
          if (odata !== q_data[0] || oaddr !== q_addr[0]) begin
            n_fail++;
            $display("FAIL bp_data got=%h@%0d exp=%h@%0d",
                     odata, oaddr, q_data[0], q_addr[0]);
          end
          void'(q_data.pop_front());
          void'(q_addr.pop_front());
          void'(q_sat.pop_front());
          got++;
        end
      end
      stalled = oen && !ordy;
      held = {oen, odata, oaddr, osat};
      if (ien && irdy) begin
        model_accept(idata, sent, 4, 0);
        sent++;
        have = 0;
      end
    end
    ien = 1'b0;
    n_run++;
    if (got != 16 || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=16 left=%0d",
               got, q_data.size());
    end
  endtask

  task automatic test_addr_error();
    int seq[5] = '{0, 1, 3, 4, 5};
    do_reset();
    istg = 4'd10; iinv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      ien   = (i < 5);
      iaddr = (i < 5) ? 10'(seq[i]) : 10'd0;
      idata = $urandom;
      @(negedge clk);
      n_run++;
      if (oerr !== (i >= 3)) begin
        n_fail++;
        $display("FAIL aerr cyc=%0d got=%b exp=%b",
                 i, oerr, i >= 3);
      end
    end
    ien = 1'b0;
    do_reset();
    @(negedge clk);
    n_run++;
    if (oerr !== 1'b0) begin
      n_fail++; $display("FAIL aerr_clr got=%b exp=0", oerr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] e;
    int seen;
    do_reset();
    istg = 4'd4; iinv = 1'b1; idata = PASS_V;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ien = 1'b1; iaddr = 10'(i); ordy = (i == 0);
    end
    @(negedge clk);
    n_run++;
    if (irdy !== 1'b0 || oen !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_full irdy=%b oen=%b exp=0/1", irdy, oen);
    end
    @(posedge clk); #1;
    irst = 1'b1; ien = 1'b0; ordy = 1'b0;
    @(posedge clk); #1;
    ordy = 1'b1;
    @(negedge clk);
    n_run++;
    if (oen !== 1'b0 || irdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst oen=%b irdy=%b exp=0/0", oen, irdy);
    end
    @(posedge clk); #1;
    irst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ien = (i == 4) || (i == 5);
      iaddr = (i == 4) ? 10'h300 : 10'h00C;
      istg = 4'd4; iinv = 1'b1;
      @(negedge clk);
      if (oen === 1'b1) begin
        seen++;
        e = (oaddr == 10'h300) ? ROT_F_V : PASS_V;
        n_run++;
        if (odata !== e || seen > 2) begin
          n_fail++;
          $display("FAIL mid_out a=%h got=%h exp=%h n=%0d",
                   oaddr, odata, e, seen);
        end
      end
    end
    ien = 1'b0;
    n_run++;
    if (seen != 2) begin
      n_fail++; $display("FAIL mid_count got=%0d exp=2", seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 420; c++) begin
        @(posedge clk); #1;
        if (c < 400) begin
          ien  = $urandom_range(0, 3) != 0;
          ordy = $urandom_range(0, 3) != 0;
        end else begin
          ien  = 1'b0;
          ordy = 1'b1;
        end
        istg = 4'($urandom_range(0, 15));
        iinv = 1'($urandom_range(0, 1));
        if (r > 0 && $urandom_range(0, 19) == 0)
          iaddr = 10'($urandom);
        else if ($urandom_range(0, 29) == 0)
          iaddr = 10'd0;
        else
          iaddr = 10'(m_exp);
        d = $urandom;
        if ($urandom_range(0, 7) == 0) d[31:16] = 16'h8000;
        if ($urandom_range(0, 7) == 0) d[15:0]  = 16'h8000;
        idata = d;
        @(negedge clk);
        n_run++;
        if (irdy !== !(q_data.size() == 2 && !ordy)) begin
          n_fail++;
          $display("FAIL rnd_irdy got=%b occ=%0d", irdy,
                   q_data.size());
        end
        n_run++;
        if (oerr !== m_err) begin
          n_fail++;
          $display("FAIL rnd_err got=%b exp=%b", oerr, m_err);
        end
        if (oen === 1'b1 && ordy) begin
          n_run++;
          if (q_data.size() == 0) begin
            n_fail++;
            $display("FAIL rnd_extra got=%h exp=none", odata);
          end else begin
            if (odata !== q_data[0] || oaddr !== q_addr[0] ||
                osat !== q_sat[0]) begin
              n_fail++;
              $display("FAIL rnd_out got=%h@%h/%b exp=%h@%h/%b",
                       odata, oaddr, osat,
                       q_data[0], q_addr[0], q_sat[0]);
            end
            void'(q_data.pop_front());
            void'(q_addr.pop_front());
            void'(q_sat.pop_front());
          end
        end
        if (ien && irdy)
          model_accept(idata, int'(iaddr), int'(istg), int'(iinv));
      end
      n_run++;
      if (q_data.size() != 0) begin
        n_fail++;
        $display("FAIL rnd_lost left=%0d exp=0", q_data.size());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    irst = 1'b1; ien = 1'b1; ordy = 1'b1;
    idata = 32'hDEAD_BEEF; iaddr = 10'd0;
    istg = 4'd4; iinv = 1'b1;
    test_reset();
    test_forward();
    test_inverse();
    test_saturation();
    test_backpressure();
    test_addr_error();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ftrans_rot.md
Name: ftrans_rot

Overview:
Parametrised trivial-twiddle rotator for radix-2^2 FFT/IFFT pipelines. It sits between butterfly stages. It multiplies samples by -j (forward) or +j (inverse) when the two address bits that select the twiddle are both 1; all other samples pass through unchanged. Successor to the fixed -j stage, adding:
- runtime stage select
- inverse mode
- valid/ready backpressure
- address-sequence checking

Parameters:
DATA_W, 16, width of each real/imag component (two's complement)
TOTAL_STAGE, 10, address width; max FFT size 2^TOTAL_STAGE
STG_W, 4, width of istg; must satisfy 2^STG_W > TOTAL_STAGE

Ports:
iclk  in  1  clock, all logic on rising edge
irst  in  1  synchronous reset, active-high
ien  in  1  input sample valid
irdy  out  1  block can accept a sample
idata  in  2*DATA_W  complex input; real [2*DATA_W-1:DATA_W], imag [DATA_W-1:0]
iaddr  in  TOTAL_STAGE  sample index within frame
istg  in  STG_W  local stage size; rotate bits are iaddr[istg-1], iaddr[istg-2]
iinv  in  1  1 = inverse (+j), 0 = forward (-j)
oen  out  1  output sample valid
ordy  in  1  downstream ready
odata  out  2*DATA_W  rotated/passed complex sample
oaddr  out  TOTAL_STAGE  iaddr delayed with its sample
osat  out  1  pulses with oen when negation saturated (0 when feature off)
oerr  out  1  sticky address-sequence error

Behaviour:
- Reset values:
  - oen=0, odata=0, oaddr=0, osat=0, oerr=0, irdy=0 while irst=1.
  - Latched config: stg=TOTAL_STAGE, inv=0. Expected-address counter = 0.
  - Reset mid-frame discards both pipeline stages with no output.
- Handshake:
  - A transfer occurs on a cycle with ien&irdy (input side) or oen&ordy (output side).
  - Two-stage elastic pipeline: S1 captures input and decodes rotation; S2 is the output register.
  - Pipeline advance: S2 loads when !S2valid | ordy. S1 loads when S1 empty or S1 moves to S2.
  - irdy = !irst & (!S1valid | !S2valid | ordy). irdy may depend combinationally on ordy.
  - Latency: 2 cycles from accept to oen when ordy is held high. Throughput: 1 sample/cycle.
  - While oen=1 & ordy=0, odata/oaddr/osat hold stable.
- Config latch:
  - istg and iinv are sampled only on an accepted sample with iaddr==0 (frame start).
  - Changes at any other time are ignored until the next frame start.
  - The sample carrying iaddr==0 uses the new config.
- Rotation decode (latched stg = s):
  - If s<2, pass-through for all samples.
  - Else rot = iaddr[s-1] & iaddr[s-2].
- Arithmetic:
  - rot & !inv: (re, im) -> (im, -re).
  - rot & inv: (re, im) -> (-im, re).
  - !rot: unchanged.
  - Negation in DATA_W bits. Without the optional feature, -(-2^(DATA_W-1)) wraps to -2^(DATA_W-1).
- Address check:
  - The expected counter increments, mod 2^s, on each accepted sample.
  - An accepted iaddr==0 resets it: expected next = 1.
  - An accepted iaddr != expected (and iaddr != 0) sets oerr, which stays set until irst. The counter resyncs to iaddr+1.
- Simultaneous input accept and output drain in the same cycle must neither lose nor duplicate a sample.

Optional Feature:
FTRANS_SAT_EN
- Defined: negating -2^(DATA_W-1) yields +2^(DATA_W-1)-1, and osat=1 for that output sample.
- Undefined: two's-complement wrap as above, and osat is tied 0.
- No latency change either way.

Test Plan:
1. Forward, DATA_W=16, istg=4, ordy=1:
   - Stimulus: frame addr 0..15, idata={re=100, im=-200}.
   - Required: addr 12..15 give {re=-200, im=-100}; all others unchanged. oen exactly 2 cycles after each ien. oerr=0.
2. Inverse, iinv=1 at addr 0, istg=4:
   - Stimulus: addr 12 with {re=100, im=-200}.
   - Required: out {re=200, im=100}. Toggling iinv at addr 5 has no effect until the next addr 0.
3. Backpressure:
   - Stimulus: stream 16 samples with ordy toggling 1,0,0,1 periodically.
   - Required: all 16 samples out in order, none lost or duplicated. irdy=0 only when both stages are full and ordy=0. Outputs stable while stalled.
4. Saturation, addr 12, forward:
   - Stimulus: {re=-32768, im=5}.
   - Required: feature on gives {re=5, im=32767} with osat=1; feature off gives {re=5, im=-32768} with osat=0.
5. Address error:
   - Stimulus: accept addr 0, 1, 3.
   - Required: oerr rises after the addr-3 accept and stays 1. Only irst clears it. Next expected address = 4.
6. Reset mid-frame:
   - Stimulus: assert irst with both stages full.
   - Required: next cycle oen=0 and irdy=0. After release, no stale output appears and stg=TOTAL_STAGE until an addr-0 sample is accepted.
